// File: rtl/cla_4bit_adder.sv
// Registered 4-bit carry-look-ahead adder slice: {Cout,Sum} <= A + B, one clock latency.
// All carries are flattened two-level sum-of-products of g/p terms, so depth is bit-independent.
module cla_4bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;
    logic [3:0] sum_s;
    logic [3:0] sum_r;
    logic       cout_r;

    // Generate/propagate terms and parallel look-ahead carries (no carry feeds another).
    always_comb begin
        g_s    = A & B;
        p_s    = A ^ B;
        c_s[0] = 1'b0;
        c_s[1] = g_s[0];
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0]);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        sum_s  = p_s ^ c_s[3:0];
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r  <= 4'h0;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_s;
            cout_r <= c_s[4];
        end
    end

    assign Sum  = sum_r;
    assign Cout = cout_r;

endmodule

// File: tb/tb_cla_4bit_adder.sv
// Self-checking bench for cla_4bit_adder: reset, exhaustive sweep, carry boundaries, latency, mid-stream reset.
module tb_cla_4bit_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sum;
    logic       Cout;

    int checks = 0;
    int errors = 0;

    cla_4bit_adder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Sum  (Sum),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed {Cout,Sum}=%b required %b", tag, observed, expected);
        end
    endtask

    // Apply inputs at the falling edge, then sample #1 after the next rising edge.
    task automatic apply_and_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                                   input logic rst, input logic [4:0] expected);
        @(negedge clk);
        A     = a;
        B     = b;
        rst_n = rst;
        @(posedge clk);
        #1;
        check_result(tag, {Cout, Sum}, expected);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp_val;
    } vec_t;

    vec_t directed[6];
    vec_t lat_vec[3];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        directed[0] = '{4'hF, 4'h1, 5'b10000};
        directed[1] = '{4'h7, 4'h9, 5'b10000};
        directed[2] = '{4'hA, 4'h5, 5'b01111};
        directed[3] = '{4'h3, 4'h4, 5'b00111};
        directed[4] = '{4'h8, 4'h8, 5'b10000};
        directed[5] = '{4'h0, 4'h0, 5'b00000};
        lat_vec[0]  = '{4'h1, 4'h1, 5'b00010};
        lat_vec[1]  = '{4'h2, 4'h2, 5'b00100};
        lat_vec[2]  = '{4'h7, 4'h8, 5'b01111};

        rst_n = 1'b0;
        A     = 4'hF;
        B     = 4'hF;

        // Reset held for two edges with max inputs.
        apply_and_check("reset_edge1", 4'hF, 4'hF, 1'b0, 5'b00000);
        apply_and_check("reset_edge2", 4'hF, 4'hF, 1'b0, 5'b00000);
        apply_and_check("reset_release", 4'hF, 4'hF, 1'b1, 5'b11110);

        for (int i = 0; i < 6; i++)
            apply_and_check($sformatf("directed_%0d", i), directed[i].a, directed[i].b, 1'b1,
                            directed[i].exp_val);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply_and_check($sformatf("sweep_%0d_%0d", a, b), 4'(a), 4'(b), 1'b1, 5'(a + b));
            end
        end

        // Outputs must hold the previous result until the edge after new inputs.
        apply_and_check("lat_prime", 4'h0, 4'h0, 1'b1, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = lat_vec[i].a;
            B = lat_vec[i].b;
            #1;
            check_result($sformatf("lat_hold_%0d", i), {Cout, Sum},
                         (i == 0) ? 5'b00000 : lat_vec[i-1].exp_val);
            @(posedge clk);
            #1;
            check_result($sformatf("lat_new_%0d", i), {Cout, Sum}, lat_vec[i].exp_val);
        end

        // Reset asserted between edges must not affect outputs until the edge.
        @(negedge clk);
        A     = 4'h9;
        B     = 4'h9;
        rst_n = 1'b0;
        #1;
        check_result("sync_rst_no_async", {Cout, Sum}, 5'b01111);
        @(posedge clk);
        #1;
        check_result("mid_reset", {Cout, Sum}, 5'b00000);
        apply_and_check("mid_reset_release", 4'h9, 4'h9, 1'b1, 5'b10010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
